// File: rtl/configurable_lut.sv
// Field-configurable K-input LUT with a serial, double-buffered config chain.
// A shadow register collects the bits and commits them to the active table only on a load of exactly the right length.
module configurable_lut #(
  parameter int INPUTS   = 4,
  parameter int WIDTH    = 1 << INPUTS,
  parameter int CFG_BITS = WIDTH + 1,
  parameter int CNT_W    = $clog2(CFG_BITS + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              config_en,
  input  logic              config_in,
  output logic              config_out,
  output logic              config_done,
  output logic              config_error,
  output logic              configured,
  input  logic [INPUTS-1:0] s,
  output logic              z
);

  localparam int              SUB      = WIDTH / 4;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    CONF   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CFG_BITS-1:0] shadow;
  logic [WIDTH-1:0]    active;
  logic                mode;
  logic [CNT_W-1:0]    count;
  logic                z_q;
  logic                start_load;
  logic                commit_ok;
  logic                commit_bad;
  logic [3:0]          sub_sel;
  logic [3:0]          hot;
  logic                sel;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNCONF;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    case (state)
      UNCONF, CONF: begin
        if (config_en) begin
          state_nxt  = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        if (!config_en) begin
          if (count == CNT_FULL) begin
            commit_ok = 1'b1;
            state_nxt = CONF;
          end else begin
            // A rejected load falls back to whatever was in use before it.
            commit_bad = 1'b1;
            state_nxt  = configured ? CONF : UNCONF;
          end
        end
      end
      default: state_nxt = UNCONF;
    endcase
  end

  // Pulses during the commit cycle; the new table is live from the next cycle.
  assign config_done = commit_ok;
  assign config_out  = shadow[0];

  // NOTE: the table storage is plain flops with reset, because an unconfigured LUT must read as all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      active       <= '0;
      mode         <= 1'b0;
      count        <= '0;
      config_error <= 1'b0;
      configured   <= 1'b0;
      z_q          <= 1'b0;
    end else begin
      if (config_en) shadow <= {config_in, shadow[CFG_BITS-1:1]};

      if (start_load)
        count <= CNT_ONE;
      else if (state == LOAD && config_en && count != CNT_SAT)
        count <= count + CNT_ONE;

      if (start_load)      config_error <= 1'b0;
      else if (commit_bad) config_error <= 1'b1;

      if (commit_ok) begin
        active     <= shadow[WIDTH-1:0];
        mode       <= shadow[WIDTH];
        configured <= 1'b1;
      end

      z_q <= sel;
    end
  end

  // Lower select bits index within each quarter table; the top two bits choose the quarter.
  generate
    if (INPUTS == 2) begin : g_small
      assign sub_sel = active[3:0];
    end else begin : g_big
      logic [SUB-1:0] sub_tab [4];
      for (genvar k = 0; k < 4; k++) begin : g_sub
        assign sub_tab[k] = active[k*SUB +: SUB];
        assign sub_sel[k] = sub_tab[k][s[INPUTS-3:0]];
      end
    end
  endgenerate

  always_comb begin
    hot = 4'b0000;
    case (s[INPUTS-1:INPUTS-2])
      2'b00: hot = 4'b0001;
      2'b01: hot = 4'b0010;
      2'b10: hot = 4'b0100;
      2'b11: hot = 4'b1000;
    endcase
  end

  assign sel = |(hot & sub_sel);
  assign z   = configured ? (mode ? z_q : sel) : 1'b0;

endmodule

// File: tb/tb_configurable_lut.sv
// Directed bench for configurable_lut (INPUTS=2): vector tables for lookups,
// hand-written sequences for loads, registered latency, chaining and reset.
module tb_configurable_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b, cin;
  logic [1:0] s;
  logic       out_a, done_a, err_a, cfgd_a, z_a;
  logic       out_b, done_b, err_b, cfgd_b, z_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  configurable_lut #(.INPUTS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .config_en(en_a), .config_in(cin),
    .config_out(out_a), .config_done(done_a), .config_error(err_a),
    .configured(cfgd_a), .s(s), .z(z_a)
  );

  configurable_lut #(.INPUTS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .config_en(en_b), .config_in(out_a),
    .config_out(out_b), .config_done(done_b), .config_error(err_b),
    .configured(cfgd_b), .s(s), .z(z_b)
  );

  typedef struct {
    int         grp;
    logic       use_b;
    logic [1:0] s;
    logic       z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational sweep of one vector group.
  task automatic run_vecs(input int grp, input string tag);
    foreach (vecs[i]) begin
      if (vecs[i].grp == grp) begin
        s = vecs[i].s;
        #1;
        check($sformatf("%s s=%0d", tag, vecs[i].s), vecs[i].use_b ? z_b : z_a, vecs[i].z);
      end
    end
  endtask

  task automatic load_a(input logic [15:0] bits, input int n, input logic exp_done, input string tag);
    for (int i = 0; i < n; i++) begin
      en_a = 1'b1;
      cin  = bits[i];
      tick();
    end
    en_a = 1'b0;
    cin  = 1'b0;
    #1;
    check({tag, " done"}, done_a, exp_done);
    tick();
    check({tag, " done_off"}, done_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] chain_bits;

    // grp0: reset sweep, grp1: XOR table on A, grp2: table 1,1,0,0 on B
    for (int i = 0; i < 4; i++) vecs.push_back('{0, 1'b0, 2'(i), 1'b0});
    vecs.push_back('{1, 1'b0, 2'd0, 1'b0});
    vecs.push_back('{1, 1'b0, 2'd1, 1'b1});
    vecs.push_back('{1, 1'b0, 2'd2, 1'b1});
    vecs.push_back('{1, 1'b0, 2'd3, 1'b0});
    vecs.push_back('{2, 1'b1, 2'd0, 1'b1});
    vecs.push_back('{2, 1'b1, 2'd1, 1'b1});
    vecs.push_back('{2, 1'b1, 2'd2, 1'b0});
    vecs.push_back('{2, 1'b1, 2'd3, 1'b0});

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; cin = 1'b0; s = 2'd0;
    #12;
    rst_n = 1'b1;
    tick();

    // 1. reset state
    check("rst configured", cfgd_a, 1'b0);
    check("rst done", done_a, 1'b0);
    check("rst error", err_a, 1'b0);
    check("rst config_out", out_a, 1'b0);
    run_vecs(0, "rst z");

    // 2. XOR table, combinational mode
    s = 2'd1;
    load_a(16'b00110, 5, 1'b1, "xor");
    check("xor configured", cfgd_a, 1'b1);
    check("xor error", err_a, 1'b0);
    run_vecs(1, "xor z");

    // 3. table 1,0,0,0 registered mode
    s = 2'd3;
    load_a(16'b10001, 5, 1'b1, "reg");
    s = 2'd0;
    #1;
    check("reg latency hold0", z_a, 1'b0);
    tick();
    check("reg s0", z_a, 1'b1);
    s = 2'd1;
    #1;
    check("reg latency hold1", z_a, 1'b1);
    tick();
    check("reg s1", z_a, 1'b0);
    s = 2'd0;
    tick();
    check("reg s0 again", z_a, 1'b1);

    // 4. short and overlong loads leave the XOR table in place
    load_a(16'b00110, 5, 1'b1, "xor2");
    s = 2'd1;
    for (int i = 0; i < 4; i++) begin
      en_a = 1'b1;
      cin  = 1'b1;
      tick();
      check("short midload z", z_a, 1'b1);
    end
    en_a = 1'b0;
    cin  = 1'b0;
    #1;
    check("short done", done_a, 1'b0);
    tick();
    check("short error", err_a, 1'b1);
    check("short configured", cfgd_a, 1'b1);
    run_vecs(1, "short z");
    load_a(16'b111111, 6, 1'b0, "long");
    check("long error", err_a, 1'b1);
    check("long configured", cfgd_a, 1'b1);
    run_vecs(1, "long z");

    // 6. async reset mid-load, then a clean reload
    s = 2'd1;
    for (int i = 0; i < 3; i++) begin
      en_a = 1'b1;
      cin  = 1'b1;
      tick();
      if (i == 0) check("entry clears error", err_a, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("midrst z", z_a, 1'b0);
    check("midrst configured", cfgd_a, 1'b0);
    check("midrst error", err_a, 1'b0);
    check("midrst done", done_a, 1'b0);
    check("midrst config_out", out_a, 1'b0);
    en_a = 1'b0;
    cin  = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    load_a(16'b00110, 5, 1'b1, "postrst");
    check("postrst configured", cfgd_a, 1'b1);
    run_vecs(1, "postrst z");

    // 5. two chained LUTs: B takes the first 5 bits, A sees 10 (overlong)
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chain_bits = 10'b10101_00011;
    for (int i = 0; i < 10; i++) begin
      en_a = 1'b1;
      en_b = (i >= 5);
      cin  = chain_bits[i];
      #1;
      check($sformatf("chain delay c%0d", i), out_a, (i >= 5) ? chain_bits[i-5] : 1'b0);
      tick();
    end
    en_a = 1'b0;
    en_b = 1'b0;
    cin  = 1'b0;
    #1;
    check("chain B done", done_b, 1'b1);
    check("chain A done", done_a, 1'b0);
    tick();
    check("chain B configured", cfgd_b, 1'b1);
    check("chain B error", err_b, 1'b0);
    check("chain A error", err_a, 1'b1);
    check("chain A configured", cfgd_a, 1'b0);
    check("chain B config_out", out_b, 1'b1);
    run_vecs(2, "chain B z");
    check("chain A z", z_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
